// File: rtl/frodo_sample_pack.sv
// frodo_sample_pack: FrodoKEM error-sample generator and packer.
// Each 16-bit random word becomes one 5-bit signed-magnitude sample, {mag[3:0], sign}.
// S consecutive samples are packed into one sCol-shaped word, which leaves over a
// valid/ready handshake.
// Build option: define FRODO_SAMPLE_PACK_PARALLEL_EN to use L-1 comparators in
// parallel, so each sample completes in its accept cycle. The default build uses a
// single comparator stepped by a small IDLE/CMP FSM over L-1 cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting to accept a random word (serial build only)
// ST_CMP  | walking the CDF table, one threshold per cycle; constant time
module frodo_sample_pack #(
  parameter int S   = 8,
  parameter int SET = 640
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic [15:0]    in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [5*S-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int L  = (SET == 976) ? 11 : (SET == 1344) ? 7 : 13;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  if (SET != 640 && SET != 976 && SET != 1344) begin : g_bad_set
    $error("frodo_sample_pack: unsupported SET %0d", SET);
  end

  // The final table entry (32767) is never compared: no 15-bit value exceeds it.
  function automatic logic [14:0] cdf_at(input logic [3:0] i);
    logic [14:0] t;
    t = 15'd32767;
    if (SET == 976) begin
      case (i)
        4'd0:    t = 15'd5638;
        4'd1:    t = 15'd15915;
        4'd2:    t = 15'd23689;
        4'd3:    t = 15'd28571;
        4'd4:    t = 15'd31116;
        4'd5:    t = 15'd32217;
        4'd6:    t = 15'd32613;
        4'd7:    t = 15'd32731;
        4'd8:    t = 15'd32760;
        4'd9:    t = 15'd32766;
        default: t = 15'd32767;
      endcase
    end else if (SET == 1344) begin
      case (i)
        4'd0:    t = 15'd9142;
        4'd1:    t = 15'd23462;
        4'd2:    t = 15'd30338;
        4'd3:    t = 15'd32361;
        4'd4:    t = 15'd32725;
        4'd5:    t = 15'd32765;
        default: t = 15'd32767;
      endcase
    end else begin
      case (i)
        4'd0:    t = 15'd4643;
        4'd1:    t = 15'd13363;
        4'd2:    t = 15'd20579;
        4'd3:    t = 15'd25843;
        4'd4:    t = 15'd29227;
        4'd5:    t = 15'd31145;
        4'd6:    t = 15'd32103;
        4'd7:    t = 15'd32525;
        4'd8:    t = 15'd32689;
        4'd9:    t = 15'd32745;
        4'd10:   t = 15'd32762;
        4'd11:   t = 15'd32766;
        default: t = 15'd32767;
      endcase
    end
    return t;
  endfunction

  logic           accept;
  logic           smp_done;
  logic [4:0]     smp;
  logic           out_free;
  logic           wrap;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           out_valid_q;
  logic [5*S-1:0] out_data_q;

  // A pending word blocks new input unless it is consumed in the same cycle.
  assign out_free = !out_valid_q || out_ready;

`ifdef FRODO_SAMPLE_PACK_PARALLEL_EN
  logic [3:0] mag;

  // Full comparator bank: count thresholds exceeded by the incoming word.
  always_comb begin
    mag = '0;
    for (int i = 0; i < L - 1; i++) begin
      if (in_data[15:1] > cdf_at(4'(i))) mag = mag + 4'd1;
    end
  end

  assign in_ready = out_free && !rst && !clear;
  assign accept   = in_valid && in_ready;
  assign smp      = {mag, in_data[0]};
  assign smp_done = accept;
`else
  typedef enum logic {ST_IDLE, ST_CMP} state_t;

  localparam logic [3:0] LAST_IDX = 4'(L - 2);

  state_t      state_q;
  logic [14:0] prnd_q;
  logic        sign_q;
  logic [3:0]  acc_q;
  logic [3:0]  idx_q;
  logic [3:0]  acc_d;

  assign acc_d    = acc_q + {3'b000, (prnd_q > cdf_at(idx_q))};
  assign in_ready = (state_q == ST_IDLE) && out_free && !rst && !clear;
  assign accept   = in_valid && in_ready;
  assign smp      = {acc_d, sign_q};
  assign smp_done = (state_q == ST_CMP) && (idx_q == LAST_IDX);

  // Serial CDF walk: latch the word, then one threshold compare per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prnd_q  <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            prnd_q  <= in_data[15:1];
            sign_q  <= in_data[0];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_CMP;
          end
        end
        ST_CMP: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`endif

  assign wrap  = (cnt_q == CW'(S - 1));
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

  // Packer: drop each finished sample into its slot; the S-th raises out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (smp_done) begin
        for (int k = 0; k < S; k++) begin
          if (cnt_q == CW'(k)) out_data_q[k*5 +: 5] <= smp;
        end
        cnt_q <= cnt_d;
      end
      if (smp_done && wrap) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_frodo_sample_pack.sv
// Bench for frodo_sample_pack: directed steps plus randomized traffic against a
// queue-based reference model; two extra S=1 instances cover SET=1344 and SET=976.
module tb_frodo_sample_pack;

  localparam int S = 8;
`ifdef FRODO_SAMPLE_PACK_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT640  = PAR ? 0 : 12;
  localparam int LAT1344 = PAR ? 0 : 6;
  localparam int LAT976  = PAR ? 0 : 10;

  int t640[13]  = '{4643, 13363, 20579, 25843, 29227, 31145, 32103, 32525, 32689,
                    32745, 32762, 32766, 32767};
  int t976[11]  = '{5638, 15915, 23689, 28571, 31116, 32217, 32613, 32731, 32760,
                    32766, 32767};
  int t1344[7]  = '{9142, 23462, 30338, 32361, 32725, 32765, 32767};

  logic           clk;
  logic           rst;
  logic           clear;
  logic [15:0]    in_data;
  logic           in_valid;
  logic           in_ready;
  logic [5*S-1:0] out_data;
  logic           out_valid;
  logic           out_ready;

  logic [15:0]    b_data;
  logic           b_valid;
  logic           b_ordy;
  logic           a_ready, a_valid;
  logic [4:0]     a_data;
  logic           c_ready, c_valid;
  logic [4:0]     c_data;

  int checks;
  int errors;
  int n;
  bit last_acc;
  logic [4:0] samp_q[$];
  int         done_q[$];

  frodo_sample_pack #(.S(S), .SET(640)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  frodo_sample_pack #(.S(1), .SET(1344)) u_d1344 (
    .clk(clk), .rst(rst), .clear(clear), .in_data(b_data), .in_valid(b_valid),
    .in_ready(a_ready), .out_data(a_data), .out_valid(a_valid), .out_ready(b_ordy)
  );

  frodo_sample_pack #(.S(1), .SET(976)) u_d976 (
    .clk(clk), .rst(rst), .clear(clear), .in_data(b_data), .in_valid(b_valid),
    .in_ready(c_ready), .out_data(c_data), .out_valid(c_valid), .out_ready(b_ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: count thresholds (all but the last) strictly below the 15-bit value.
  function automatic logic [4:0] ref_sample(input logic [15:0] r, input int set);
    int p;
    int m;
    p = int'(r[15:1]);
    m = 0;
    case (set)
      976:     for (int i = 0; i < 10; i++) if (p > t976[i])  m++;
      1344:    for (int i = 0; i < 6;  i++) if (p > t1344[i]) m++;
      default: for (int i = 0; i < 12; i++) if (p > t640[i])  m++;
    endcase
    return {m[3:0], r[0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance model.
  task automatic step(input logic iv, input logic [15:0] d, input logic orr,
                      input logic clr, input logic rs);
    int ncomp;
    bit inflight;
    logic exp_v, exp_rdy;
    logic [5*S-1:0] w;
    ncomp    = 0;
    inflight = 0;
    foreach (done_q[i]) begin
      if (done_q[i] <= n) ncomp++;
      else inflight = 1;
    end
    exp_v     = (ncomp >= S);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    clear     = clr;
    rst       = rs;
    #1;
    exp_rdy = !rs && !clr && (!exp_v || orr) && !inflight;
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_v) begin
      w = '0;
      for (int k = 0; k < S; k++) w[k*5 +: 5] = samp_q[k];
      chk("out_data", 64'(out_data), 64'(w));
    end
    last_acc = iv && exp_rdy;
    if (rs || clr) begin
      samp_q.delete();
      done_q.delete();
    end else begin
      if (exp_v && orr) begin
        for (int k = 0; k < S; k++) begin
          void'(samp_q.pop_front());
          void'(done_q.pop_front());
        end
      end
      if (last_acc) begin
        samp_q.push_back(ref_sample(d, 640));
        done_q.push_back(n + 1 + LAT640);
      end
    end
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic feed(input logic [15:0] d, input logic orr);
    int k;
    k = 0;
    last_acc = 0;
    while (!last_acc && k < 64) begin
      step(1'b1, d, orr, 1'b0, 1'b0);
      k++;
    end
    chk("feed_accepted", 64'(last_acc), 64'd1);
  endtask

  task automatic idle(input int cycles, input logic orr);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0000, orr, 1'b0, 1'b0);
  endtask

  logic [15:0]    pk_in  [8] = '{16'h0000, 16'h2449, 16'h2448, 16'hFFFF,
                                  16'h0001, 16'h2448, 16'h0000, 16'hFFFF};
  logic [4:0]     pk_exp [8] = '{5'b00000, 5'b00011, 5'b00010, 5'b11001,
                                  5'b00001, 5'b00010, 5'b00000, 5'b11001};
  logic [4:0]     m2_exp [4] = '{5'b00000, 5'b00010, 5'b00011, 5'b11001};
  logic [5*S-1:0] pk_word;

  initial begin
    logic [15:0] d;
    int p;
    checks = 0;
    errors = 0;
    n      = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_valid = 1'b0; b_data = '0; b_ordy = 1'b1;
    pk_word = '0;
    for (int k = 0; k < 8; k++) pk_word[k*5 +: 5] = pk_exp[k];
    repeat (2) @(posedge clk);
    #1;

    // Reset state, and in_ready low while rst is held.
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    idle(1, 1'b0);

    // Packing vector; mapping constants checked per slot.
    for (int i = 0; i < 8; i++) feed(pk_in[i], 1'b0);
    idle(LAT640, 1'b0);
    for (int k = 0; k < 8; k++) chk("pack_slot", 64'(out_data[k*5 +: 5]), 64'(pk_exp[k]));

    // Backpressure: word held constant, no input accepted.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h2446, 1'b0, 1'b0, 1'b0);
      chk("hold_data", 64'(out_data), 64'(pk_word));
    end
    // Consume and accept in the same cycle.
    feed(16'h2446, 1'b1);
    feed(16'h2448, 1'b1);
    feed(16'h2449, 1'b1);
    feed(16'hFFFF, 1'b1);
    for (int i = 0; i < 4; i++) feed(16'($urandom), 1'b1);
    idle(LAT640, 1'b0);
    for (int k = 0; k < 4; k++) chk("map_slot", 64'(out_data[k*5 +: 5]), 64'(m2_exp[k]));
    idle(1, 1'b1);

    // clear mid-sample after 5 samples, then a fresh word.
    for (int i = 0; i < 6; i++) feed(16'($urandom), 1'b1);
    idle(3, 1'b1);
    step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    idle(LAT640 + 2, 1'b1);
    for (int i = 0; i < 8; i++) feed(16'($urandom), 1'b0);
    idle(LAT640 + 1, 1'b0);
    idle(1, 1'b1);

    // rst mid-sample.
    feed(16'hFFFF, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_out_data", 64'(out_data), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    idle(1, 1'b1);

    // Randomized traffic with occasional clear and rst.
    for (int i = 0; i < 2000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        p = t640[$urandom_range(0, 12)] + int'($urandom_range(0, 1));
        d = {p[14:0], d[0]};
      end
      step(1'($urandom_range(0, 9) < 7), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 399) == 0));
    end

    // Other parameter sets on the S=1 instances.
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    b_data = 16'hFFFF; b_valid = 1'b1;
    #1;
    chk("set1344_ready", 64'(a_ready), 64'd1);
    chk("set976_ready", 64'(c_ready), 64'd1);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      chk("set1344_valid", 64'(a_valid), 64'(k == LAT1344));
      if (k == LAT1344) chk("set1344_data", 64'(a_data), 64'(5'b01101));
      chk("set976_valid", 64'(c_valid), 64'(k == LAT976));
      if (k == LAT976) chk("set976_data", 64'(c_data), 64'(5'b10101));
      @(posedge clk);
      #1;
    end
    chk("set1344_model", 64'(ref_sample(16'hFFFF, 1344)), 64'(a_data));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frodo_sample_pack.md
# frodo_sample_pack

Error-sample generator and packer feeding the matrix-multiply datapath. It consumes a stream of 16-bit uniform random words (SHAKE output) and maps each word through the FrodoKEM cumulative distribution table to one 5-bit signed-magnitude sample: bit 0 is the sign (1 = negative) and bits 4:1 are the magnitude. This is exactly the encoding the multiplier decodes. It packs S consecutive samples into one word shaped like the multiplier's sCol vector and delivers it over a valid/ready handshake.

## Interface
- S, 8: samples per output word.
- SET, 640: parameter set; selects the CDF table. The table length L, with the final entry 32767, is fixed per set:
  - 640: 4643,13363,20579,25843,29227,31145,32103,32525,32689,32745,32762,32766,32767 (L=13).
  - 976: 5638,15915,23689,28571,31116,32217,32613,32731,32760,32766,32767 (L=11).
  - 1344: 9142,23462,30338,32361,32725,32765,32767 (L=7).
  - Any other SET value is a compile-time error.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort; discards any partial word and any pending word.
- in_data  in  16  random word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  5*S  packed samples; sample k in bits k*5+:5; sample 0 is the first accepted.
- out_valid  out  1  out_data holds S complete samples.
- out_ready  in  1  consumer takes out_data this cycle.

## Operation
- Sample mapping for word r:
  - sign = r[0], prnd = r[15:1].
  - mag = number of i in 0..L-2 with prnd > T[i].
  - Result is {mag[3:0], sign}.
  - The comparison is unsigned, 15-bit.
  - A sample of -0 ({0,1}) is legal and passed through unchanged.
- Packing:
  - A 2-bit-free slot counter cnt runs 0..S-1.
  - Each finished sample is written to slot cnt, then cnt increments.
  - Writing slot S-1 sets cnt to 0 and sets out_valid.
- Output:
  - out_valid clears on out_valid & out_ready unless a new S-th sample completes in the same cycle.
  - out_data is stable while out_valid & !out_ready.
  - Slots not yet rewritten keep their old values; out_data is meaningful only while out_valid is high.
- Serial mode (default). FSM with states IDLE and CMP:
  - IDLE: in_ready = (!out_valid | out_ready) & !rst & !clear. On accept: latch the word, set acc=0 and idx=0, go to CMP.
  - CMP: each cycle acc += (prnd > T[idx]) and idx++. In the cycle with idx == L-2, write {acc_final, sign} to the slot and go to IDLE.
  - in_ready = 0 throughout CMP.
  - Every CMP sequence runs the full L-1 cycles regardless of data, so timing is constant.
- clear:
  - Sets cnt=0, out_valid=0 and the FSM to IDLE.
  - Drops an in-flight sample.
  - Forces in_ready=0 in that cycle.
  - clear overrides accept and out_ready.

## Timing
- Reset values:
  - out_valid=0, out_data=0, cnt=0, FSM=IDLE.
  - in_ready=0 while rst is high; it is 1 in the first cycle after rst.
- Serial mode:
  - Accept at edge t; the sample is written at edge t+(L-1).
  - Throughput is one sample per L cycles (13/11/7).
  - The S-th sample's write edge raises out_valid.
- Parallel mode: the sample is written at the accept edge, so throughput is one sample per cycle with zero extra latency.
- Simultaneous consume and accept (out_valid & out_ready & accept):
  - Legal, including when the new sample lands in slot 0.
  - If this accept completes the next word (S=1 or parallel), out_valid stays 1.
- rst during CMP: the result is discarded and the block follows the reset values.
- clear and rst together: rst wins; the result is identical.

## Configuration
- FRODO_SAMPLE_PACK_PARALLEL_EN
  - Defined: L-1 parallel comparators and no CMP state; the sample completes in the accept cycle.
  - Undefined: the serial single-comparator FSM above, for minimum area.
- Sample values, packing order and handshake behaviour are identical in both modes; only latency and throughput differ.

## Test plan
- Mapping, SET=640, S=1:
  - in_data 16'h0000 -> 5'b00000.
  - 16'hFFFF -> 5'b11001 (mag 12, negative).
  - 16'h2446 -> 5'b00000.
  - 16'h2448 -> 5'b00010.
  - 16'h2449 -> 5'b00011.
- Packing, S=8: feed 0x0000, 0x2449, 0x2448, 0xFFFF, 0x0001, 0x2448, 0x0000, 0xFFFF -> out_data slots 0..7 = 00000, 00011, 00010, 11001, 00001, 00010, 00000, 11001; out_valid rises on the 8th write.
- Serial latency, SET=640: accept at cycle 0 -> the sample is written at the edge ending cycle 12; in_ready=0 in cycles 1..12 and 1 again in cycle 13.
- Backpressure: hold out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0 and out_data constant for 20 cycles. Raise out_ready -> the word is consumed and the next sample is accepted in the same cycle.
- clear and rst:
  - Assert clear after 5 samples, mid-CMP -> out_valid stays 0, cnt=0, and the next 8 samples form a fresh word.
  - rst mid-CMP -> all reset values observed next cycle.
- Other sets: SET=1344 with 16'hFFFF -> 5'b01101 (mag 6), serial latency 6 cycles. SET=976 with 16'hFFFF -> 5'b10101 (mag 10).
